alu_rs: RTL
===========

ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 The module SHALL have ports:
- clk_in  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- rdy_in  input  1  global ready; when low, all state SHALL be held.
- clr_in  input  1  misprediction flush from the ROB.
- iss_valid  input  1  the decoder issues one ALU-class instruction this cycle.
- iss_op  input  6  internal opcode, e.g. ADD, SUB, BEQ or JALR.
- iss_vj, iss_vk  input  32 each  operand values.
- iss_qj_busy, iss_qk_busy  input  1 each  the operand is still pending.
- iss_qj, iss_qk  input  4 each  ROB tag of the pending operand.
- iss_rob  input  4  destination ROB tag.
- alu_cdb_valid, alu_cdb_rob, alu_cdb_val  input  1/4/32  ALU result broadcast.
- lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val  input  1/4/32  load result broadcast.
- full  output  1  no free entry is available.
- ex_flag  output  1  an instruction is dispatched to the ALU.
- ex_val1, ex_val2  output  32 each  ALU operands.
- ex_op  output  6  ALU opcode.
- ex_rob  output  4  ROB tag of the dispatched instruction.

Function
REQ-002 The block SHALL hold 8 entries; each entry SHALL be {busy, op, vj, vk, qj_busy, qj, qk_busy, qk, rob}.
REQ-003 full SHALL be combinational and SHALL be 1 exactly when all 8 entries are busy.
REQ-004 Issue: when iss_valid=1 and full=0, the lowest-index free entry SHALL be written at the clock edge.
REQ-005 iss_valid=1 while full=1 is an upstream protocol violation; the instruction SHALL be dropped and no entry SHALL change.
REQ-006 Snoop: each busy entry with qj_busy=1 whose qj matches a valid CDB tag SHALL capture that CDB value into vj and clear qj_busy. The qk fields SHALL behave the same way.
REQ-007 Both CDB ports SHALL be snooped in the same cycle. If both carry the same tag, the ALU CDB SHALL take priority.
REQ-008 Issue bypass: an operand issued with q*_busy=1 whose tag matches a CDB valid in the same cycle SHALL be stored as ready, holding the CDB value.
REQ-009 Dispatch candidate: a busy entry with qj_busy=0 and qk_busy=0 at the start of the cycle. The lowest-index candidate SHALL be selected, with at most one dispatch per cycle.
REQ-010 On dispatch, the ex_* outputs SHALL be registered from the selected entry and ex_flag SHALL be 1 for one cycle. The entry SHALL be freed at the same edge.
REQ-011 If there is no candidate, ex_flag SHALL be 0. ex_val1, ex_val2, ex_op and ex_rob SHALL be 0 in that case.
REQ-012 Latency rules:
- An entry written at edge N SHALL dispatch no earlier than edge N+1.
- An operand captured from the CDB at edge N SHALL make the entry eligible from edge N+1.
REQ-013 A freed entry SHALL be reusable by an issue in the following cycle. Issue into a slot freed in the same cycle is not required.
REQ-014 Flush: clr_in=1 at an edge SHALL clear every busy bit and set ex_flag=0. Issue, snoop and dispatch in that cycle SHALL be ignored.
REQ-015 Stall: with rdy_in=0, entries and ex_* outputs SHALL hold. clr_in SHALL still take effect.
REQ-016 Operand values SHALL be passed through unmodified; no arithmetic is done in this block.

Reset
REQ-017 rst_n=0 SHALL immediately clear all busy bits and drive ex_flag=0, ex_val1=0, ex_val2=0, ex_op=0 and ex_rob=0, independent of the clock.
REQ-018 After rst_n rises, full SHALL be 0 and the first issue SHALL land in entry 0.
REQ-019 An assertion of rst_n mid-operation SHALL discard all entries with no partial dispatch.

Verification
REQ-020 Ready issue: issue ADD with vj=5, vk=7, both ready, rob=3 at edge N.
-> At edge N+1: ex_flag=1, ex_val1=5, ex_val2=7, ex_op=ADD, ex_rob=3.
-> At edge N+2: ex_flag=0.
REQ-021 Pending operand: issue SUB with qj_busy=1, qj=6, vk=2, then alu_cdb {valid=1, rob=6, val=0x10} two cycles later at edge M.
-> Dispatch at edge M+1 with ex_val1=0x10, ex_val2=2.
REQ-022 Bypass and priority: issue with qk=9 pending while alu_cdb rob=9 val=0xAA and lsb_cdb rob=9 val=0xBB are both valid.
-> The entry dispatches next edge with ex_val2=0xAA.
REQ-023 Full: issue 8 instructions with pending operands.
-> full=1.
-> A 9th iss_valid changes nothing.
-> Resolving entry 2's operands frees it; the next issue lands in entry 2.
REQ-024 Ordering: entries 1 and 4 become ready in the same cycle.
-> Entry 1 dispatches first, entry 4 on the next cycle.
REQ-025 Flush and reset:
-> clr_in with 5 busy entries: full=0, ex_flag=0, and no dispatch afterwards.
-> rst_n low between edges: outputs zero immediately.

Source files
------------

// File: rtl/alu_rs_if.sv
// Issue, CDB snoop and execute-dispatch signals between the decoder/CDB side and the ALU
// reservation station.
interface alu_rs_if;
  logic        iss_valid;
  logic [5:0]  iss_op;
  logic [31:0] iss_vj;
  logic [31:0] iss_vk;
  logic        iss_qj_busy;
  logic        iss_qk_busy;
  logic [3:0]  iss_qj;
  logic [3:0]  iss_qk;
  logic [3:0]  iss_rob;
  logic        alu_cdb_valid;
  logic [3:0]  alu_cdb_rob;
  logic [31:0] alu_cdb_val;
  logic        lsb_cdb_valid;
  logic [3:0]  lsb_cdb_rob;
  logic [31:0] lsb_cdb_val;
  logic        full;
  logic        ex_flag;
  logic [31:0] ex_val1;
  logic [31:0] ex_val2;
  logic [5:0]  ex_op;
  logic [3:0]  ex_rob;

  modport slave (
    input  iss_valid, iss_op, iss_vj, iss_vk, iss_qj_busy, iss_qk_busy, iss_qj, iss_qk, iss_rob,
    input  alu_cdb_valid, alu_cdb_rob, alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val,
    output full, ex_flag, ex_val1, ex_val2, ex_op, ex_rob
  );

  modport master (
    output iss_valid, iss_op, iss_vj, iss_vk, iss_qj_busy, iss_qk_busy, iss_qj, iss_qk, iss_rob,
    output alu_cdb_valid, alu_cdb_rob, alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val,
    input  full, ex_flag, ex_val1, ex_val2, ex_op, ex_rob
  );
endinterface

// File: rtl/alu_rs.sv
// Eight-entry ALU reservation station: issues into the lowest free slot, snoops both CDBs and
// dispatches the lowest-index ready entry each cycle.
module alu_rs (
  input  logic    clk_in,
  input  logic    rst_n,
  input  logic    rdy_in,
  input  logic    clr_in,
  alu_rs_if.slave bus
);
  localparam int Depth = 8;
  localparam int IdxW  = 3;

  typedef struct packed {
    logic        busy;
    logic [5:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic        qj_busy;
    logic [3:0]  qj;
    logic        qk_busy;
    logic [3:0]  qk;
    logic [3:0]  rob;
  } entry_t;

  entry_t [Depth-1:0] ent_q, ent_d;
  logic               ex_flag_q, ex_flag_d;
  logic [31:0]        ex_val1_q, ex_val1_d;
  logic [31:0]        ex_val2_q, ex_val2_d;
  logic [5:0]         ex_op_q, ex_op_d;
  logic [3:0]         ex_rob_q, ex_rob_d;

  logic [Depth-1:0]   busy_vec;
  logic               free_found, disp_found;
  logic [IdxW-1:0]    free_idx, disp_idx;

  // Returns {still_pending, value}; the ALU CDB wins when both ports carry the same tag.
  function automatic logic [32:0] resolve(input logic pend, input logic [3:0] tag,
                                          input logic [31:0] val,
                                          input logic av, input logic [3:0] at,
                                          input logic [31:0] ad,
                                          input logic lv, input logic [3:0] lt,
                                          input logic [31:0] ld);
    logic [32:0] r;
    r = {pend, val};
    if (pend && av && (at == tag)) begin
      r = {1'b0, ad};
    end else if (pend && lv && (lt == tag)) begin
      r = {1'b0, ld};
    end
    return r;
  endfunction

  always_comb begin
    busy_vec   = '0;
    free_found = 1'b0;
    free_idx   = '0;
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int i = 0; i < Depth; i++) begin
      busy_vec[i] = ent_q[i].busy;
      if (!free_found && !ent_q[i].busy) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
      if (!disp_found && ent_q[i].busy && !ent_q[i].qj_busy && !ent_q[i].qk_busy) begin
        disp_found = 1'b1;
        disp_idx   = IdxW'(i);
      end
    end
  end

  assign bus.full = &busy_vec;

  always_comb begin
    ent_d     = ent_q;
    ex_flag_d = 1'b0;
    ex_val1_d = '0;
    ex_val2_d = '0;
    ex_op_d   = '0;
    ex_rob_d  = '0;
    if (clr_in) begin
      for (int i = 0; i < Depth; i++) begin
        ent_d[i].busy = 1'b0;
      end
    end else if (!rdy_in) begin
      ex_flag_d = ex_flag_q;
      ex_val1_d = ex_val1_q;
      ex_val2_d = ex_val2_q;
      ex_op_d   = ex_op_q;
      ex_rob_d  = ex_rob_q;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (ent_q[i].busy) begin
          {ent_d[i].qj_busy, ent_d[i].vj} = resolve(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj,
              bus.alu_cdb_valid, bus.alu_cdb_rob, bus.alu_cdb_val,
              bus.lsb_cdb_valid, bus.lsb_cdb_rob, bus.lsb_cdb_val);
          {ent_d[i].qk_busy, ent_d[i].vk} = resolve(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk,
              bus.alu_cdb_valid, bus.alu_cdb_rob, bus.alu_cdb_val,
              bus.lsb_cdb_valid, bus.lsb_cdb_rob, bus.lsb_cdb_val);
        end
      end
      if (disp_found) begin
        ex_flag_d = 1'b1;
        ex_val1_d = ent_q[disp_idx].vj;
        ex_val2_d = ent_q[disp_idx].vk;
        ex_op_d   = ent_q[disp_idx].op;
        ex_rob_d  = ent_q[disp_idx].rob;
        ent_d[disp_idx].busy = 1'b0;
      end
      // free_idx comes from the registered busy bits, so it never aliases the dispatching slot.
      if (bus.iss_valid && free_found) begin
        ent_d[free_idx].busy = 1'b1;
        ent_d[free_idx].op   = bus.iss_op;
        ent_d[free_idx].qj   = bus.iss_qj;
        ent_d[free_idx].qk   = bus.iss_qk;
        ent_d[free_idx].rob  = bus.iss_rob;
        {ent_d[free_idx].qj_busy, ent_d[free_idx].vj} = resolve(bus.iss_qj_busy, bus.iss_qj,
            bus.iss_vj, bus.alu_cdb_valid, bus.alu_cdb_rob, bus.alu_cdb_val,
            bus.lsb_cdb_valid, bus.lsb_cdb_rob, bus.lsb_cdb_val);
        {ent_d[free_idx].qk_busy, ent_d[free_idx].vk} = resolve(bus.iss_qk_busy, bus.iss_qk,
            bus.iss_vk, bus.alu_cdb_valid, bus.alu_cdb_rob, bus.alu_cdb_val,
            bus.lsb_cdb_valid, bus.lsb_cdb_rob, bus.lsb_cdb_val);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      ent_q     <= '0;
      ex_flag_q <= 1'b0;
      ex_val1_q <= '0;
      ex_val2_q <= '0;
      ex_op_q   <= '0;
      ex_rob_q  <= '0;
    end else begin
      ent_q     <= ent_d;
      ex_flag_q <= ex_flag_d;
      ex_val1_q <= ex_val1_d;
      ex_val2_q <= ex_val2_d;
      ex_op_q   <= ex_op_d;
      ex_rob_q  <= ex_rob_d;
    end
  end

  assign bus.ex_flag = ex_flag_q;
  assign bus.ex_val1 = ex_val1_q;
  assign bus.ex_val2 = ex_val2_q;
  assign bus.ex_op   = ex_op_q;
  assign bus.ex_rob  = ex_rob_q;
endmodule
